control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_pkg.sv | 23 ++
 rtl/control_fsm.sv | 98 +++++++++
 tb/tb_control_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared state enumeration and constants for the control_fsm sequencer.
package control_pkg;

   localparam int unsigned NUM_STATES = 14;

   typedef enum logic [3:0] {
      S_T0  = 4'd0,
      S_T1  = 4'd1,
      S_T2  = 4'd2,
      S_T3  = 4'd3,
      S_T4  = 4'd4,
      S_T5  = 4'd5,
      S_T6  = 4'd6,
      S_T7  = 4'd7,
      S_T8  = 4'd8,
      S_T9  = 4'd9,
      S_T10 = 4'd10,
      S_T11 = 4'd11,
      S_T12 = 4'd12,
      S_T13 = 4'd13
   } state_e;

endpackage

// File: rtl/control_fsm.sv
// Password / fire / AC control sequencer with one-hot state outputs.
// Optional macro CTRL_STATE_OUT_EN adds the binary state_code output.
module control_fsm
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       p,
   input  logic       f,
   input  logic       d,
   input  logic       pm,
   input  logic       ptl,
   input  logic       dtl,
   input  logic       pt,
   input  logic       pp,
   input  logic       tl,
   input  logic       rh,
   output logic       t0,
   output logic       t1,
   output logic       t2,
   output logic       t3,
   output logic       t4,
   output logic       t5,
   output logic       t6,
   output logic       t7,
   output logic       t8,
   output logic       t9,
   output logic       t10,
   output logic       t11,
   output logic       t12,
   output logic       t13
`ifdef CTRL_STATE_OUT_EN
   ,
   output logic [3:0] state_code
`endif
);

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_T0;
      end else if (load) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_T0: begin
            if (p)      state_d = S_T1;
            else if (f) state_d = S_T8;
            else if (d) state_d = S_T10;
         end
         S_T1:  state_d = S_T2;
         S_T2: begin
            if (pm)       state_d = S_T5;
            else if (ptl) state_d = S_T3;
         end
         S_T3:  state_d = S_T4;
         S_T4:  state_d = S_T0;
         S_T5:  state_d = S_T6;
         S_T6:  if (dtl) state_d = S_T7;
         S_T7:  state_d = S_T4;
         S_T8:  if (pt) state_d = S_T9;
         S_T9:  state_d = S_T4;
         S_T10: if (pp && tl) state_d = S_T11;
         S_T11: state_d = S_T12;
         S_T12: if (rh) state_d = S_T13;
         S_T13: state_d = S_T4;
         // Encodings 14/15 are unreachable; recover to idle.
         default: state_d = S_T0;
      endcase
   end

   assign t0  = (state_q == S_T0);
   assign t1  = (state_q == S_T1);
   assign t2  = (state_q == S_T2);
   assign t3  = (state_q == S_T3);
   assign t4  = (state_q == S_T4);
   assign t5  = (state_q == S_T5);
   assign t6  = (state_q == S_T6);
   assign t7  = (state_q == S_T7);
   assign t8  = (state_q == S_T8);
   assign t9  = (state_q == S_T9);
   assign t10 = (state_q == S_T10);
   assign t11 = (state_q == S_T11);
   assign t12 = (state_q == S_T12);
   assign t13 = (state_q == S_T13);

`ifdef CTRL_STATE_OUT_EN
   assign state_code = state_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm; follows CTRL_STATE_OUT_EN if defined.
module tb_control_fsm;

   logic clk = 1'b0;
   logic reset, load, p, f, d, pm, ptl, dtl, pt, pp, tl, rh;
   logic t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13;
`ifdef CTRL_STATE_OUT_EN
   logic [3:0] state_code;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .p     (p),
      .f     (f),
      .d     (d),
      .pm    (pm),
      .ptl   (ptl),
      .dtl   (dtl),
      .pt    (pt),
      .pp    (pp),
      .tl    (tl),
      .rh    (rh),
      .t0    (t0),
      .t1    (t1),
      .t2    (t2),
      .t3    (t3),
      .t4    (t4),
      .t5    (t5),
      .t6    (t6),
      .t7    (t7),
      .t8    (t8),
      .t9    (t9),
      .t10   (t10),
      .t11   (t11),
      .t12   (t12),
      .t13   (t13)
`ifdef CTRL_STATE_OUT_EN
      ,
      .state_code (state_code)
`endif
   );

   task automatic check(input int idx, input string tag);
      logic [13:0] obs;
      logic [13:0] exp;
      obs = {t13, t12, t11, t10, t9, t8, t7, t6, t5, t4, t3, t2, t1, t0};
      exp = 14'd1 << idx;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
`ifdef CTRL_STATE_OUT_EN
      checks++;
      assert (state_code === 4'(idx)) else begin
         errors++;
         $error("FAIL %s_code: observed %0d expected %0d", tag, state_code, idx);
      end
`endif
   endtask

   task automatic step(input int idx, input string tag);
      @(posedge clk);
      #1;
      check(idx, tag);
   endtask

   initial begin
      reset = 1'b0; load = 1'b1; p = 1'b1; f = 1'b0; d = 1'b0;
      pm = 1'b0; ptl = 1'b0; dtl = 1'b0; pt = 1'b0; pp = 1'b0; tl = 1'b0; rh = 1'b0;
      #2;
      check(0, "rst_async");
      step(0, "rst_hold1");
      step(0, "rst_hold2");

      // Password accepted path
      reset = 1'b1;
      step(1, "pw_t1");
      p = 1'b0;
      step(2, "pw_t2");
      pm = 1'b1;
      step(5, "pw_t5");
      pm = 1'b0;
      step(6, "pw_t6");
      step(6, "pw_t6_hold");
      dtl = 1'b1;
      step(7, "pw_t7");
      dtl = 1'b0;
      step(4, "pw_t4");
      step(0, "pw_t0");

      // Lockout and pm-over-ptl priority
      p = 1'b1;
      step(1, "lk_t1");
      p = 1'b0;
      step(2, "lk_t2");
      step(2, "lk_t2_hold");
      ptl = 1'b1;
      step(3, "lk_t3");
      ptl = 1'b0;
      step(4, "lk_t4");
      step(0, "lk_t0");
      p = 1'b1;
      step(1, "pri_t1");
      p = 1'b0;
      step(2, "pri_t2");
      pm = 1'b1; ptl = 1'b1;
      step(5, "pri_pm_wins");
      pm = 1'b0; ptl = 1'b0;
      step(6, "pri_t6");
      dtl = 1'b1;
      step(7, "pri_t7");
      dtl = 1'b0;
      step(4, "pri_t4");
      step(0, "pri_t0");

      // Fire path, with level-sensitive restart
      f = 1'b1;
      step(8, "fire_t8");
      step(8, "fire_hold1");
      step(8, "fire_hold2");
      step(8, "fire_hold3");
      pt = 1'b1;
      step(9, "fire_t9");
      pt = 1'b0;
      step(4, "fire_t4");
      step(0, "fire_t0");
      step(8, "fire_restart");
      f = 1'b0; pt = 1'b1;
      step(9, "fire_t9b");
      pt = 1'b0;
      step(4, "fire_t4b");
      step(0, "fire_t0b");

      // AC path
      d = 1'b1;
      step(10, "ac_t10");
      d = 1'b0; pp = 1'b1; tl = 1'b0;
      step(10, "ac_tl_low_hold");
      tl = 1'b1;
      step(11, "ac_t11");
      pp = 1'b0; tl = 1'b0;
      step(12, "ac_t12");
      step(12, "ac_t12_hold");
      rh = 1'b1;
      step(13, "ac_t13");
      rh = 1'b0;
      step(4, "ac_t4");
      step(0, "ac_t0");

      // f beats d at idle
      f = 1'b1; d = 1'b1;
      step(8, "pri_f_over_d");
      f = 1'b0; d = 1'b0; pt = 1'b1;
      step(9, "pri_t9");
      pt = 1'b0;
      step(4, "pri_t4b");
      step(0, "pri_t0b");

      // load gating with all requests active
      load = 1'b0; p = 1'b1; f = 1'b1; d = 1'b1;
      for (int i = 0; i < 5; i++) step(0, "load_off_hold");
      load = 1'b1;
      step(1, "load_on_p");

      // Reset mid-sequence, then t0 rules on first enabled edge
      p = 1'b0; f = 1'b0; d = 1'b0;
      step(2, "mid_t2");
      reset = 1'b0;
      #1;
      check(0, "mid_rst_async");
      step(0, "mid_rst_hold");
      reset = 1'b1; d = 1'b1;
      step(10, "post_rst_t10");
      load = 1'b0; d = 1'b0; pp = 1'b1; tl = 1'b1;
      step(10, "t10_load_off");
      load = 1'b1;
      step(11, "t10_load_on");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
